unidade_controle_alu: RTL and testbench

//  Multicycle control FSM that drives the ALU. It accepts one RV32I instruction
//  per handshake and decodes it into an ALU op code, operand selects and an

---
 rtl/alu_pkg.sv | 58 +++++
 rtl/unidade_controle_alu_if.sv | 39 +++
 rtl/gerador_imediato.sv | 34 +++
 rtl/unidade_controle_alu.sv | 176 +++++++++++++++++
 tb/tb_unidade_controle_alu.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package    : alu_pkg                                                  |
// | Description: Shared constants and types for the ALU control unit:    |
// |              ALU op codes, RV32I opcode/funct fields, FSM states.     |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
package alu_pkg;

    // Default number of cycles to wait for memory before aborting
    localparam int TIMEOUT_MEM_PADRAO = 16;

    // ALU operation codes driven on resultado_alu_control
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    // RV32I major opcodes used by the supported subset
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // funct3 / funct7 values of the supported instructions
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_LH   = 3'b001;
    localparam logic [2:0] F3_SH   = 3'b001;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [6:0] F7_BASE = 7'b0000000;

    // Controller states
    typedef enum logic [2:0] {
        BUSCA      = 3'd0,
        DECODIFICA = 3'd1,
        EXECUTA    = 3'd2,
        COMPARA    = 3'd3,
        MEMORIA    = 3'd4,
        ESCRITA    = 3'd5
    } estado_t;

    // Instruction class after decode; selects the path through the FSM
    typedef enum logic [2:0] {
        CLS_R      = 3'd0,
        CLS_ANDI   = 3'd1,
        CLS_LH     = 3'd2,
        CLS_SH     = 3'd3,
        CLS_BNE    = 3'd4,
        CLS_ILEGAL = 3'd5
    } classe_t;

endpackage
`default_nettype wire

// File: rtl/unidade_controle_alu_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface  : unidade_controle_alu_if                                 |
// | Description: Fetch handshake, ALU control and memory request bundle  |
// |              between the controller (slave) and its environment.    |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
interface unidade_controle_alu_if;
    logic [31:0] instrucao;
    logic        instr_valida;
    logic        instr_pronta;
    logic [3:0]  resultado_alu_control;
    logic        sel_valor2;
    logic [31:0] imediato;
    logic [4:0]  rd;
    logic        escreve_reg;
    logic        le_mem;
    logic        escreve_mem;
    logic        mem_pronta;
    logic        resultado_desvio;
    logic        pc_desvio;
    logic        ilegal;
    logic        erro_mem;

    // Fetch / datapath / memory side
    modport master (
        output instrucao, instr_valida, mem_pronta, resultado_desvio,
        input  instr_pronta, resultado_alu_control, sel_valor2, imediato, rd,
               escreve_reg, le_mem, escreve_mem, pc_desvio, ilegal, erro_mem
    );

    // Controller side
    modport slave (
        input  instrucao, instr_valida, mem_pronta, resultado_desvio,
        output instr_pronta, resultado_alu_control, sel_valor2, imediato, rd,
               escreve_reg, le_mem, escreve_mem, pc_desvio, ilegal, erro_mem
    );
endinterface
`default_nettype wire

// File: rtl/gerador_imediato.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : gerador_imediato                                         |
// | Description: Combinational I/S/B immediate extraction, selected by   |
// |              opcode and sign-extended to 32 bits.                    |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module gerador_imediato
    import alu_pkg::*;
(
    input  logic [31:0] instrucao,
    output logic [31:0] imediato
);
    // rs1/funct3 field never carries immediate bits in I/S/B formats
    logic unused_campos;
    assign unused_campos = ^instrucao[19:12];

    // Pick the immediate layout from the opcode; other formats yield zero
    always_comb begin
        imediato = '0;
        case (instrucao[6:0])
            OPC_OP_IMM, OPC_LOAD:
                imediato = {{20{instrucao[31]}}, instrucao[31:20]};
            OPC_STORE:
                imediato = {{20{instrucao[31]}}, instrucao[31:25], instrucao[11:7]};
            OPC_BRANCH:
                imediato = {{19{instrucao[31]}}, instrucao[31], instrucao[7],
                            instrucao[30:25], instrucao[11:8], 1'b0};
            default:
                imediato = '0;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/unidade_controle_alu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : unidade_controle_alu                                     |
// | Description: Multicycle control FSM for the ALU. Decodes one RV32I   |
// |              instruction per handshake and sequences execute,        |
// |              compare, memory and writeback.                          |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module unidade_controle_alu
    import alu_pkg::*;
#(
    parameter int TIMEOUT_MEM = TIMEOUT_MEM_PADRAO
) (
    input  logic                  clock,
    input  logic                  reset,
    unidade_controle_alu_if.slave bus
);
    localparam int             CNT_W      = $clog2(TIMEOUT_MEM);
    localparam logic [CNT_W-1:0] CNT_ULTIMO = CNT_W'(TIMEOUT_MEM - 1);

    estado_t          estado, prox_estado;
    logic [31:0]      instr_q;
    classe_t          classe_q, classe_dec;
    logic [3:0]       codigo_q, codigo_dec;
    logic             sel_q, sel_dec;
    logic [4:0]       rd_q, rd_dec;
    logic [31:0]      imed_q, imed_dec;
    logic [CNT_W-1:0] cnt_q;
    logic             fim_espera;
    logic             escreve_reg_q, le_mem_q, escreve_mem_q;
    logic             pc_desvio_q, ilegal_q, erro_mem_q;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    assign opcode = instr_q[6:0];
    assign funct3 = instr_q[14:12];
    assign funct7 = instr_q[31:25];

    gerador_imediato u_gerador_imediato (
        .instrucao (instr_q),
        .imediato  (imed_dec)
    );

    // Decode the held instruction into class, ALU code, operand select and rd
    always_comb begin
        classe_dec = CLS_ILEGAL;
        codigo_dec = ALU_ADD;
        sel_dec    = 1'b0;
        rd_dec     = '0;
        case (opcode)
            OPC_OP: begin
                rd_dec = instr_q[11:7];
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        F3_ADD:  begin classe_dec = CLS_R; codigo_dec = ALU_ADD; end
                        F3_OR:   begin classe_dec = CLS_R; codigo_dec = ALU_OR;  end
                        F3_SLL:  begin classe_dec = CLS_R; codigo_dec = ALU_SLL; end
                        default: classe_dec = CLS_ILEGAL;
                    endcase
                end
            end
            OPC_OP_IMM: if (funct3 == F3_AND) begin
                classe_dec = CLS_ANDI; codigo_dec = ALU_AND; sel_dec = 1'b1;
                rd_dec = instr_q[11:7];
            end
            OPC_LOAD: if (funct3 == F3_LH) begin
                classe_dec = CLS_LH; codigo_dec = ALU_ADD; sel_dec = 1'b1;
                rd_dec = instr_q[11:7];
            end
            OPC_STORE: if (funct3 == F3_SH) begin
                classe_dec = CLS_SH; codigo_dec = ALU_ADD; sel_dec = 1'b1;
            end
            OPC_BRANCH: if (funct3 == F3_BNE) begin
                classe_dec = CLS_BNE; codigo_dec = ALU_SUB; sel_dec = 1'b0;
            end
            default: classe_dec = CLS_ILEGAL;
        endcase
    end

    // Memory wait expired without completion (completion on the same cycle wins)
    assign fim_espera = (estado == MEMORIA) && !bus.mem_pronta && (cnt_q == CNT_ULTIMO);

    // Next-state selection
    always_comb begin
        prox_estado = estado;
        case (estado)
            BUSCA:      if (bus.instr_valida) prox_estado = DECODIFICA;
            DECODIFICA: prox_estado = (classe_dec == CLS_ILEGAL) ? BUSCA : EXECUTA;
            EXECUTA: begin
                case (classe_q)
                    CLS_LH, CLS_SH: prox_estado = MEMORIA;
                    CLS_BNE:        prox_estado = COMPARA;
                    default:        prox_estado = ESCRITA;
                endcase
            end
            COMPARA:    prox_estado = BUSCA;
            MEMORIA: begin
                if (bus.mem_pronta)
                    prox_estado = (classe_q == CLS_LH) ? ESCRITA : BUSCA;
                else if (fim_espera)
                    prox_estado = BUSCA;
            end
            ESCRITA:    prox_estado = BUSCA;
            default:    prox_estado = BUSCA;
        endcase
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) estado <= BUSCA;
        else       estado <= prox_estado;
    end

    // Capture the instruction only on a handshake in BUSCA
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                                    instr_q <= '0;
        else if (estado == BUSCA && bus.instr_valida) instr_q <= bus.instrucao;
    end

    // Register decoded fields; an illegal word leaves the previous values intact
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            classe_q <= CLS_R;
            codigo_q <= ALU_ADD;
            sel_q    <= 1'b0;
            rd_q     <= '0;
            imed_q   <= '0;
        end else if (estado == DECODIFICA && classe_dec != CLS_ILEGAL) begin
            classe_q <= classe_dec;
            codigo_q <= codigo_dec;
            sel_q    <= sel_dec;
            rd_q     <= rd_dec;
            imed_q   <= imed_dec;
        end
    end

    // Memory wait counter, cleared whenever the FSM is outside MEMORIA
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                  cnt_q <= '0;
        else if (estado == MEMORIA) cnt_q <= cnt_q + CNT_W'(1);
        else                        cnt_q <= '0;
    end

    // Strobes track the upcoming state; pulses report the decision just taken
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            escreve_reg_q <= 1'b0;
            le_mem_q      <= 1'b0;
            escreve_mem_q <= 1'b0;
            pc_desvio_q   <= 1'b0;
            ilegal_q      <= 1'b0;
            erro_mem_q    <= 1'b0;
        end else begin
            escreve_reg_q <= (prox_estado == ESCRITA);
            le_mem_q      <= (prox_estado == MEMORIA) && (classe_q == CLS_LH);
            escreve_mem_q <= (prox_estado == MEMORIA) && (classe_q == CLS_SH);
            pc_desvio_q   <= (estado == COMPARA) && bus.resultado_desvio;
            ilegal_q      <= (estado == DECODIFICA) && (classe_dec == CLS_ILEGAL);
            erro_mem_q    <= fim_espera;
        end
    end

    assign bus.instr_pronta          = (estado == BUSCA);
    assign bus.resultado_alu_control = codigo_q;
    assign bus.sel_valor2            = sel_q;
    assign bus.imediato              = imed_q;
    assign bus.rd                    = rd_q;
    assign bus.escreve_reg           = escreve_reg_q;
    assign bus.le_mem                = le_mem_q;
    assign bus.escreve_mem           = escreve_mem_q;
    assign bus.pc_desvio             = pc_desvio_q;
    assign bus.ilegal                = ilegal_q;
    assign bus.erro_mem              = erro_mem_q;
endmodule
`default_nettype wire

// File: tb/tb_unidade_controle_alu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : tb_unidade_controle_alu                                  |
// | Description: Self-checking bench for unidade_controle_alu. Assembles |
// |              instructions from fields and checks decode, timing and  |
// |              strobes against a latency/decode reference model.       |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module tb_unidade_controle_alu;
    localparam int TMO = 16;
    localparam int K_ADD = 0, K_OR = 1, K_SLL = 2, K_ANDI = 3;
    localparam int K_LH = 4, K_SH = 5, K_BNE = 6, K_ILL = 7;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   fails  = 0;
    int   seq    = 0;
    logic [3:0] last_code = 4'b0010;

    unidade_controle_alu_if bus ();

    unidade_controle_alu #(.TIMEOUT_MEM(TMO)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // ---------------- assembler ----------------
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
        input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_i(input int imm, input logic [4:0] rs1,
        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        logic [31:0] v;
        v = imm;
        return {v[11:0], rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input int imm, input logic [4:0] rs2,
        input logic [4:0] rs1, input logic [2:0] f3, input logic [6:0] op);
        logic [31:0] v;
        v = imm;
        return {v[11:5], rs2, rs1, f3, v[4:0], op};
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input logic [4:0] rs2,
        input logic [4:0] rs1, input logic [2:0] f3, input logic [6:0] op);
        logic [31:0] v;
        v = imm;
        return {v[12], v[10:5], rs2, rs1, f3, v[4:1], v[11], op};
    endfunction

    // ---------------- reference model ----------------
    function automatic logic [3:0] model_code(input int kind);
        case (kind)
            K_OR:    return 4'b0001;
            K_SLL:   return 4'b0011;
            K_ANDI:  return 4'b0000;
            K_BNE:   return 4'b0110;
            default: return 4'b0010;
        endcase
    endfunction

    function automatic int model_latency(input int kind, input int nmem);
        case (kind)
            K_LH:    return 4 + nmem;
            K_SH:    return (nmem > 0) ? 3 + nmem : 3 + TMO;
            K_ILL:   return 2;
            default: return 4;
        endcase
    endfunction

    // Issue one instruction and follow it until the controller is ready again.
    // nmem: memory wait cycles (0 = memory never answers); flag: bne compare result
    task automatic run(input int kind, input logic [31:0] instr, input int exp_imm,
                       input logic [4:0] exp_rd, input int nmem, input logic flag);
        int k, g, lat, nw, wk, nle, nem, npc, nil, ner;
        logic [3:0] c2, c3;
        logic s2;
        logic [4:0] rd2;
        logic [31:0] im2;
        logic done, writer;
        g = 0;
        while (bus.instr_pronta !== 1'b1 && g < 50) begin
            @(negedge clock);
            g++;
        end
        seq++;
        writer = (kind <= K_LH);
        bus.instrucao = instr;
        bus.instr_valida = 1'b1;
        bus.mem_pronta = 1'b0;
        k = 0; lat = 0; nw = 0; wk = 0; nle = 0; nem = 0; npc = 0; nil = 0; ner = 0;
        c2 = 'x; c3 = 'x; s2 = 'x; rd2 = 'x; im2 = 'x;
        done = 1'b0;
        while (!done && k < 40) begin
            @(negedge clock);
            k++;
            if (k == 2) begin
                c2 = bus.resultado_alu_control; s2 = bus.sel_valor2;
                rd2 = bus.rd; im2 = bus.imediato;
            end
            if (k == 3) c3 = bus.resultado_alu_control;
            if (bus.escreve_reg === 1'b1) begin
                nw++;
                if (wk == 0) wk = k;
            end
            if (bus.le_mem === 1'b1)      nle++;
            if (bus.escreve_mem === 1'b1) nem++;
            if (bus.pc_desvio === 1'b1)   npc++;
            if (bus.ilegal === 1'b1)      nil++;
            if (bus.erro_mem === 1'b1)    ner++;
            if (bus.instr_pronta === 1'b1) begin
                done = 1'b1;
                lat = k;
            end
            if (done) bus.instr_valida = 1'b0;
            else begin
                bus.instr_valida = 1'($urandom_range(0, 1));
                bus.instrucao = $urandom;
            end
            bus.mem_pronta = (nmem > 0) && (k == 2 + nmem);
            bus.resultado_desvio = (k == 3 && kind == K_BNE) ? flag : 1'($urandom_range(0, 1));
        end
        check($sformatf("latency[%0d]", seq), lat, model_latency(kind, nmem));
        check($sformatf("writes[%0d]", seq), nw, writer ? 1 : 0);
        if (writer) check($sformatf("write_cycle[%0d]", seq), wk, model_latency(kind, nmem) - 1);
        check($sformatf("le_mem_cycles[%0d]", seq), nle, (kind == K_LH) ? nmem : 0);
        check($sformatf("escreve_mem_cycles[%0d]", seq), nem,
              (kind == K_SH) ? ((nmem > 0) ? nmem : TMO) : 0);
        check($sformatf("pc_desvio[%0d]", seq), npc, (kind == K_BNE && flag) ? 1 : 0);
        check($sformatf("erro_mem[%0d]", seq), ner, (kind == K_SH && nmem == 0) ? 1 : 0);
        check($sformatf("ilegal[%0d]", seq), nil, (kind == K_ILL) ? 1 : 0);
        if (kind != K_ILL) begin
            check($sformatf("code[%0d]", seq), c2, model_code(kind));
            check($sformatf("sel_valor2[%0d]", seq), s2, (kind >= K_ANDI && kind <= K_SH) ? 1 : 0);
            if (writer) check($sformatf("rd[%0d]", seq), rd2, exp_rd);
            if (kind >= K_ANDI) check($sformatf("imediato[%0d]", seq), im2, exp_imm);
            if (kind == K_BNE) check($sformatf("code_compara[%0d]", seq), c3, 4'b0110);
            last_code = model_code(kind);
        end else begin
            check($sformatf("code_kept[%0d]", seq), c2, last_code);
        end
    endtask

    initial begin
        int kind, imm, nm;
        logic [4:0] rd, rs1, rs2;
        logic [31:0] ins;
        logic flag;
        bus.instrucao = '0;
        bus.instr_valida = 1'b0;
        bus.mem_pronta = 1'b0;
        bus.resultado_desvio = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_pronta", bus.instr_pronta, 1);
        check("rst_code", bus.resultado_alu_control, 4'b0010);
        check("rst_rd", bus.rd, 0);
        check("rst_imediato", bus.imediato, 0);
        check("rst_strobes", {bus.escreve_reg, bus.le_mem, bus.escreve_mem,
                              bus.pc_desvio, bus.ilegal, bus.erro_mem}, 0);

        // Directed cases
        run(K_ADD,  enc_r(7'd0, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011), 0, 5'd3, 0, 1'b0);
        run(K_ANDI, enc_i(-1, 5'd1, 3'b111, 5'd5, 7'b0010011), -1, 5'd5, 0, 1'b0);
        run(K_BNE,  enc_b(-8, 5'd2, 5'd1, 3'b001, 7'b1100011), -8, 5'd0, 0, 1'b1);
        run(K_BNE,  enc_b(2046, 5'd4, 5'd6, 3'b001, 7'b1100011), 2046, 5'd0, 0, 1'b0);
        run(K_LH,   enc_i(4, 5'd2, 3'b001, 5'd7, 7'b0000011), 4, 5'd7, 3, 1'b0);
        run(K_SH,   enc_s(8, 5'd3, 5'd2, 3'b001, 7'b0100011), 8, 5'd0, 3, 1'b0);
        run(K_SH,   enc_s(-2048, 5'd9, 5'd2, 3'b001, 7'b0100011), -2048, 5'd0, 0, 1'b0);
        run(K_ILL,  32'hFFFF_FFFF, 0, 5'd0, 0, 1'b0);
        run(K_LH,   enc_i(2047, 5'd8, 3'b001, 5'd31, 7'b0000011), 2047, 5'd31, TMO, 1'b0);
        run(K_LH,   enc_i(-2, 5'd8, 3'b001, 5'd1, 7'b0000011), -2, 5'd1, 1, 1'b0);
        run(K_SH,   enc_s(-1, 5'd8, 5'd3, 3'b001, 7'b0100011), -1, 5'd0, 1, 1'b0);
        run(K_OR,   enc_r(7'd0, 5'd4, 5'd5, 3'b110, 5'd6, 7'b0110011), 0, 5'd6, 0, 1'b0);
        run(K_SLL,  enc_r(7'd0, 5'd4, 5'd5, 3'b001, 5'd0, 7'b0110011), 0, 5'd0, 0, 1'b0);

        // Randomized instruction mix
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 7);
            rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
            imm = int'($urandom_range(0, 4095)) - 2048;
            nm = $urandom_range(1, TMO);
            flag = 1'($urandom_range(0, 1));
            case (kind)
                K_ADD:  ins = enc_r(7'd0, rs2, rs1, 3'b000, rd, 7'b0110011);
                K_OR:   ins = enc_r(7'd0, rs2, rs1, 3'b110, rd, 7'b0110011);
                K_SLL:  ins = enc_r(7'd0, rs2, rs1, 3'b001, rd, 7'b0110011);
                K_ANDI: ins = enc_i(imm, rs1, 3'b111, rd, 7'b0010011);
                K_LH:   ins = enc_i(imm, rs1, 3'b001, rd, 7'b0000011);
                K_SH: begin
                    ins = enc_s(imm, rs2, rs1, 3'b001, 7'b0100011);
                    if ($urandom_range(0, 4) == 0) nm = 0;
                end
                K_BNE: begin
                    imm = imm * 2;
                    ins = enc_b(imm, rs2, rs1, 3'b001, 7'b1100011);
                end
                default: begin
                    case ($urandom_range(0, 4))
                        0: ins = enc_r(7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011);
                        1: ins = enc_i(imm, rs1, 3'b110, rd, 7'b0010011);
                        2: ins = enc_i(imm, rs1, 3'b010, rd, 7'b0000011);
                        3: ins = enc_b(imm * 2, rs2, rs1, 3'b000, 7'b1100011);
                        default: ins = {20'($urandom), rd, 7'b0110111};
                    endcase
                end
            endcase
            run(kind, ins, imm, rd, (kind == K_LH || kind == K_SH) ? nm : 0, flag);
        end

        // Reset while a memory request is outstanding
        for (int r = 0; r < 2; r++) begin
            int nw;
            while (bus.instr_pronta !== 1'b1) @(negedge clock);
            bus.instrucao = (r == 0) ? enc_i(4, 5'd2, 3'b001, 5'd7, 7'b0000011)
                                     : enc_s(8, 5'd3, 5'd2, 3'b001, 7'b0100011);
            bus.instr_valida = 1'b1;
            bus.mem_pronta = 1'b0;
            @(negedge clock);
            bus.instr_valida = 1'b0;
            repeat (3) @(negedge clock);
            check($sformatf("req_before_rst[%0d]", r),
                  (r == 0) ? bus.le_mem : bus.escreve_mem, 1);
            #2 reset = 1'b1;
            #1;
            check($sformatf("req_drop_rst[%0d]", r), {bus.le_mem, bus.escreve_mem}, 0);
            check($sformatf("pronta_in_rst[%0d]", r), bus.instr_pronta, 1);
            @(negedge clock);
            reset = 1'b0;
            nw = 0;
            repeat (3) begin
                @(negedge clock);
                if (bus.escreve_reg === 1'b1) nw++;
            end
            check($sformatf("pronta_after_rst[%0d]", r), bus.instr_pronta, 1);
            check($sformatf("no_write_after_rst[%0d]", r), nw, 0);
            check($sformatf("code_after_rst[%0d]", r), bus.resultado_alu_control, 4'b0010);
            check($sformatf("rd_after_rst[%0d]", r), bus.rd, 0);
            last_code = 4'b0010;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
`default_nettype wire
